// File: rtl/regex_pkg.sv
// rtl/regex_pkg.sv - shared types and constants for the regex stream feeder
package regex_pkg;

    localparam int POS_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_MT,
        ST_STREAM,
        ST_END,
        ST_DONE
    } feeder_state_t;

    typedef struct packed {
        logic [POS_W-1:0] start_pos;
        logic [POS_W-1:0] end_pos;
    } match_result_t;

endpackage

// File: rtl/regex_stream_feeder_if.sv
// rtl/regex_stream_feeder_if.sv - host load/start, matcher drive and result drain signals
interface regex_stream_feeder_if #(
    parameter int POS_W = regex_pkg::POS_W
);
    logic             wr_en;
    logic [7:0]       wr_data;
    logic             wr_full;
    logic             start;
    logic             busy;
    logic             done;
    logic             mt_reset;
    logic [7:0]       mt_data;
    logic             mt_stream_end;
    logic             mt_rdy;
    logic             mt_match;
    logic [POS_W-1:0] mt_start_pos;
    logic [POS_W-1:0] mt_end_pos;
    logic             res_valid;
    logic             res_ready;
    logic [POS_W-1:0] res_start;
    logic [POS_W-1:0] res_end;
    logic             res_overflow;

    modport slave (
        input  wr_en, wr_data, start, mt_rdy, mt_match, mt_start_pos, mt_end_pos, res_ready,
        output wr_full, busy, done, mt_reset, mt_data, mt_stream_end,
               res_valid, res_start, res_end, res_overflow
    );

    modport master (
        output wr_en, wr_data, start, mt_rdy, mt_match, mt_start_pos, mt_end_pos, res_ready,
        input  wr_full, busy, done, mt_reset, mt_data, mt_stream_end,
               res_valid, res_start, res_end, res_overflow
    );
endinterface

// File: rtl/regex_result_fifo.sv
// rtl/regex_result_fifo.sv - synchronous FIFO of match reports with clear
module regex_result_fifo
    import regex_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  match_result_t push_data,
    input  logic          pop,
    output match_result_t head,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          do_push, do_pop;
    match_result_t mem_q [DEPTH];

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop && !empty;
        // a pop in the same cycle frees the slot the push needs
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
        head = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/regex_stream_feeder.sv
// rtl/regex_stream_feeder.sv - buffers host text, streams it into a regex matcher, collects matches
module regex_stream_feeder
    import regex_pkg::*;
#(
    parameter int BUF_DEPTH  = 256,
    parameter int RES_DEPTH  = 8,
    parameter int POS_W      = regex_pkg::POS_W,
    parameter int END_CYCLES = 2
) (
    input logic                  clk,
    input logic                  reset,
    regex_stream_feeder_if.slave bus
);
    localparam int IDX_W = $clog2(BUF_DEPTH);
    localparam int LEN_W = IDX_W + 1;
    localparam int CNT_W = $clog2(END_CYCLES + 1);

    feeder_state_t state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] end_cnt_q, end_cnt_d;
    logic             match_q, match_d;
    logic [7:0]       mt_data_q, mt_data_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       buf_mem [BUF_DEPTH];
    logic             buf_we, wr_full, in_window;
    logic             fifo_clear, fifo_push, fifo_pop, fifo_full, fifo_empty;
    match_result_t    push_data, head;

    assign wr_full   = (len_q == LEN_W'(BUF_DEPTH));
    assign in_window = (state_q == ST_STREAM) || (state_q == ST_END);
    assign fifo_pop  = !fifo_empty && bus.res_ready;
    assign push_data.start_pos = regex_pkg::POS_W'(bus.mt_start_pos);
    assign push_data.end_pos   = regex_pkg::POS_W'(bus.mt_end_pos);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        rd_ptr_d   = rd_ptr_q;
        end_cnt_d  = end_cnt_q;
        match_d    = match_q;
        mt_data_d  = mt_data_q;
        buf_we     = 1'b0;
        fifo_clear = 1'b0;
        fifo_push  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                buf_we = bus.wr_en && !wr_full;
                if (buf_we) len_d = len_q + 1'b1;
                if (bus.start) begin
                    fifo_clear = 1'b1;
                    state_d    = (len_q == '0) ? ST_DONE : ST_RST_MT;
                end
            end
            ST_RST_MT: begin
                // prefetch byte 0 so the first STREAM cycle already presents it
                match_d   = 1'b0;
                rd_ptr_d  = LEN_W'(1);
                mt_data_d = buf_mem[0];
                state_d   = ST_STREAM;
            end
            ST_STREAM: begin
                if (rd_ptr_q == len_q) begin
                    mt_data_d = 8'h00;
                    end_cnt_d = '0;
                    state_d   = ST_END;
                end else begin
                    mt_data_d = buf_mem[rd_ptr_q[IDX_W-1:0]];
                    rd_ptr_d  = rd_ptr_q + 1'b1;
                end
            end
            ST_END: begin
                if (end_cnt_q == CNT_W'(END_CYCLES - 1)) state_d = ST_DONE;
                else end_cnt_d = end_cnt_q + 1'b1;
            end
            ST_DONE: begin
                len_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // only the rising edge of the held match level produces an entry
        if (in_window && bus.mt_rdy) begin
            match_d   = bus.mt_match;
            fifo_push = bus.mt_match && !match_q;
        end
        if (fifo_clear) overflow_d = 1'b0;
        else overflow_d = overflow_q || (fifo_push && fifo_full && !fifo_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            rd_ptr_q   <= '0;
            end_cnt_q  <= '0;
            match_q    <= 1'b0;
            mt_data_q  <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            rd_ptr_q   <= rd_ptr_d;
            end_cnt_q  <= end_cnt_d;
            match_q    <= match_d;
            mt_data_q  <= mt_data_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) buf_mem[len_q[IDX_W-1:0]] <= bus.wr_data;
    end

    regex_result_fifo #(.DEPTH(RES_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (fifo_clear),
        .push      (fifo_push),
        .push_data (push_data),
        .pop       (fifo_pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.wr_full       = wr_full;
    assign bus.busy          = (state_q == ST_RST_MT) || in_window;
    assign bus.done          = (state_q == ST_DONE);
    assign bus.mt_reset      = (state_q == ST_RST_MT);
    assign bus.mt_data       = mt_data_q;
    assign bus.mt_stream_end = (state_q == ST_END);
    assign bus.res_valid     = !fifo_empty;
    assign bus.res_start     = POS_W'(head.start_pos);
    assign bus.res_end       = POS_W'(head.end_pos);
    assign bus.res_overflow  = overflow_q;
endmodule

// File: tb/tb_regex_stream_feeder.sv
// tb/tb_regex_stream_feeder.sv - directed self-checking bench for regex_stream_feeder
module tb_regex_stream_feeder;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] abc [3] = '{8'h61, 8'h62, 8'h63};

    always #5 clk = ~clk;

    regex_stream_feeder_if #(.POS_W(32)) bus ();

    regex_stream_feeder #(
        .BUF_DEPTH (256),
        .RES_DEPTH (8),
        .POS_W     (32),
        .END_CYCLES(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] b);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic start_run();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (bus.done !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        check(tag, 64'(bus.done), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_done"}, 64'(bus.done), 64'd0);
        check({tag, "_wr_full"}, 64'(bus.wr_full), 64'd0);
        check({tag, "_mt_reset"}, 64'(bus.mt_reset), 64'd0);
        check({tag, "_mt_data"}, 64'(bus.mt_data), 64'd0);
        check({tag, "_mt_end"}, 64'(bus.mt_stream_end), 64'd0);
        check({tag, "_res_valid"}, 64'(bus.res_valid), 64'd0);
        check({tag, "_overflow"}, 64'(bus.res_overflow), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic seen_done;
        bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.start = 1'b0;
        bus.mt_rdy = 1'b0; bus.mt_match = 1'b0;
        bus.mt_start_pos = '0; bus.mt_end_pos = '0; bus.res_ready = 1'b0;
        reset = 1'b1;
        step(); step();
        check_all_zero("reset");
        reset = 1'b0;
        step();

        // run timing with "abc"
        for (int i = 0; i < 3; i++) write_byte(abc[i]);
        start_run();
        for (int c = 1; c <= 7; c++) begin
            check($sformatf("abc_mt_reset_c%0d", c), 64'(bus.mt_reset), 64'(c == 1));
            check($sformatf("abc_mt_data_c%0d", c), 64'(bus.mt_data),
                  (c >= 2 && c <= 4) ? 64'(abc[c-2]) : 64'd0);
            check($sformatf("abc_mt_end_c%0d", c), 64'(bus.mt_stream_end), 64'(c == 5 || c == 6));
            check($sformatf("abc_done_c%0d", c), 64'(bus.done), 64'(c == 7));
            check($sformatf("abc_busy_c%0d", c), 64'(bus.busy), 64'(c >= 1 && c <= 6));
            step();
        end
        check("abc_idle_busy", 64'(bus.busy), 64'd0);
        check("abc_idle_done", 64'(bus.done), 64'd0);

        // full buffer, 257th write ignored
        for (int i = 0; i < 256; i++) write_byte(8'(i));
        check("full_wr_full", 64'(bus.wr_full), 64'd1);
        write_byte(8'hAA);
        check("full_still_full", 64'(bus.wr_full), 64'd1);
        start_run();
        check("full_mt_reset", 64'(bus.mt_reset), 64'd1);
        step();
        for (int i = 0; i < 256; i++) begin
            check($sformatf("full_byte_%0d", i), 64'(bus.mt_data), 64'(i));
            step();
        end
        check("full_stream_end", 64'(bus.mt_stream_end), 64'd1);
        check("full_end_data", 64'(bus.mt_data), 64'd0);
        wait_done("full_done");
        step();
        check("full_len_cleared", 64'(bus.wr_full), 64'd0);

        // single capture from a held match
        for (int i = 0; i < 8; i++) write_byte(8'h30 + 8'(i));
        start_run();
        step();
        bus.mt_rdy = 1'b1; bus.mt_match = 1'b1;
        bus.mt_start_pos = 32'd4; bus.mt_end_pos = 32'd10;
        repeat (5) step();
        bus.mt_rdy = 1'b0; bus.mt_match = 1'b0;
        wait_done("cap_done");
        step();
        check("cap_valid", 64'(bus.res_valid), 64'd1);
        check("cap_start", 64'(bus.res_start), 64'd4);
        check("cap_end", 64'(bus.res_end), 64'd10);
        check("cap_no_overflow", 64'(bus.res_overflow), 64'd0);
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        check("cap_popped_empty", 64'(bus.res_valid), 64'd0);

        // overflow: 9 pulses into an 8-deep FIFO, then pop+push while full
        for (int i = 0; i < 24; i++) write_byte(8'(i));
        start_run();
        step();
        for (int i = 0; i < 9; i++) begin
            bus.mt_rdy = 1'b1; bus.mt_match = 1'b1;
            bus.mt_start_pos = 32'(i); bus.mt_end_pos = 32'(i + 100);
            step();
            bus.mt_match = 1'b0;
            step();
        end
        check("ovf_sticky", 64'(bus.res_overflow), 64'd1);
        check("ovf_head_start", 64'(bus.res_start), 64'd0);
        bus.mt_match = 1'b1; bus.mt_start_pos = 32'd50; bus.mt_end_pos = 32'd150;
        bus.res_ready = 1'b1;
        step();
        bus.mt_rdy = 1'b0; bus.mt_match = 1'b0; bus.res_ready = 1'b0;
        wait_done("ovf_done");
        step();
        for (int i = 1; i <= 7; i++) begin
            check($sformatf("ovf_entry_start_%0d", i), 64'(bus.res_start), 64'(i));
            check($sformatf("ovf_entry_end_%0d", i), 64'(bus.res_end), 64'(i + 100));
            bus.res_ready = 1'b1;
            step();
            bus.res_ready = 1'b0;
        end
        check("ovf_last_valid", 64'(bus.res_valid), 64'd1);
        check("ovf_last_start", 64'(bus.res_start), 64'd50);
        check("ovf_last_end", 64'(bus.res_end), 64'd150);
        check("ovf_still_set", 64'(bus.res_overflow), 64'd1);

        // empty run also clears FIFO and overflow
        start_run();
        check("empty_done", 64'(bus.done), 64'd1);
        check("empty_busy", 64'(bus.busy), 64'd0);
        check("empty_mt_reset", 64'(bus.mt_reset), 64'd0);
        check("empty_fifo_cleared", 64'(bus.res_valid), 64'd0);
        check("empty_ovf_cleared", 64'(bus.res_overflow), 64'd0);
        step();
        check("empty_done_pulse", 64'(bus.done), 64'd0);

        // abort in the 3rd STREAM cycle
        for (int i = 0; i < 6; i++) write_byte(abc[i % 3]);
        start_run();
        step(); step(); step();
        check("abort_busy_before", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        step();
        check_all_zero("abort");
        reset = 1'b0;
        seen_done = 1'b0;
        repeat (8) begin
            step();
            seen_done = seen_done | bus.done | bus.busy;
        end
        check("abort_no_done", 64'(seen_done), 64'd0);
        start_run();
        check("abort_len0_done", 64'(bus.done), 64'd1);
        check("abort_len0_mt_reset", 64'(bus.mt_reset), 64'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
